// File: rtl/sev_seg_scan.sv
// Two-digit multiplexed 7-segment scanner with anti-ghost blanking and
// boundary-synchronous digit update so a digit never changes mid-slot.
module sev_seg_scan #(
  parameter logic [15:0] DIV       = 16'd50000,
  parameter logic [15:0] BLANK_CYC = 16'd500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] dig0,
  input  logic [3:0] dig1,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       ld_ack
);

  localparam logic [15:0] LAST = DIV - 16'd1;

  logic [15:0] cnt_reg;
  logic        slot_reg;
  logic        pending_reg;
  logic        boundary;
  logic [7:0]  dig_cat;
  logic [7:0]  disp_flat;
  logic [13:0] dec_flat;
  logic [6:0]  seg_next;
  logic [1:0]  an_next;

  assign boundary = (cnt_reg == LAST);
  assign dig_cat  = {dig1, dig0};

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0:    hex2seg = 7'h40;
      4'h1:    hex2seg = 7'h79;
      4'h2:    hex2seg = 7'h24;
      4'h3:    hex2seg = 7'h30;
      4'h4:    hex2seg = 7'h19;
      4'h5:    hex2seg = 7'h12;
      4'h6:    hex2seg = 7'h02;
      4'h7:    hex2seg = 7'h78;
      4'h8:    hex2seg = 7'h00;
      4'h9:    hex2seg = 7'h10;
      4'hA:    hex2seg = 7'h08;
      4'hB:    hex2seg = 7'h03;
      4'hC:    hex2seg = 7'h46;
      4'hD:    hex2seg = 7'h21;
      4'hE:    hex2seg = 7'h06;
      default: hex2seg = 7'h0E;
    endcase
  endfunction

  // Per digit: shadow takes every load; the displayed copy only moves at a
  // slot boundary, either straight from the inputs or from the shadow.
  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_digit
    logic [3:0] shadow_reg;
    logic [3:0] disp_reg;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_reg <= 4'd0;
        disp_reg   <= 4'd0;
      end else begin
        if (load) shadow_reg <= dig_cat[gi*4 +: 4];
        if (boundary && load) disp_reg <= dig_cat[gi*4 +: 4];
        else if (boundary && pending_reg) disp_reg <= shadow_reg;
      end
    end

    assign disp_flat[gi*4 +: 4] = disp_reg;
    assign dec_flat[gi*7 +: 7]  = hex2seg(disp_reg);
  end

  always_comb begin
    seg_next = 7'h7F;
    an_next  = 2'b11;
    if (cnt_reg >= BLANK_CYC) begin
      if (!slot_reg) begin
        an_next  = 2'b10;
        seg_next = dec_flat[6:0];
      end else if (!(blank_lz && (disp_flat[7:4] == 4'd0))) begin
        an_next  = 2'b01;
        seg_next = dec_flat[13:7];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= 16'd0;
      slot_reg    <= 1'b0;
      pending_reg <= 1'b0;
      seg         <= 7'h7F;
      an          <= 2'b11;
      ld_ack      <= 1'b0;
    end else begin
      seg    <= seg_next;
      an     <= an_next;
      ld_ack <= boundary && (load || pending_reg);
      if (boundary) begin
        cnt_reg     <= 16'd0;
        slot_reg    <= ~slot_reg;
        pending_reg <= 1'b0;
      end else begin
        cnt_reg <= cnt_reg + 16'd1;
        if (load) pending_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_scan.sv
// Bench for sev_seg_scan at DIV=8, BLANK_CYC=2: a time-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_sev_seg_scan;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int PER   = 2 * DIV;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic       blank_lz;
  logic [6:0] seg;
  logic [1:0] an;
  logic       ld_ack;

  int compared   = 0;
  int mismatched = 0;

  sev_seg_scan #(.DIV(16'd8), .BLANK_CYC(16'd2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .dig0(dig0), .dig1(dig1),
    .blank_lz(blank_lz), .seg(seg), .an(an), .ld_ack(ld_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: position in the 2*DIV scan period is derived from the
  // number of clock edges since reset release.
  int         m_edges;
  int         pos, c, s;
  logic [3:0] m_disp0, m_disp1, m_sh0, m_sh1;
  logic       m_pend;
  logic [6:0] exp_seg = 7'h7F;
  logic [1:0] exp_an  = 2'b11;
  logic       exp_ack = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_edges = 0; m_disp0 = 0; m_disp1 = 0; m_sh0 = 0; m_sh1 = 0; m_pend = 0;
        exp_seg = 7'h7F; exp_an = 2'b11; exp_ack = 1'b0;
      end else begin
        pos = m_edges % PER;
        c   = pos % DIV;
        s   = pos / DIV;
        if (c < BLANK) begin
          exp_seg = 7'h7F; exp_an = 2'b11;
        end else if (s == 0) begin
          exp_seg = hex_tab[m_disp0]; exp_an = 2'b10;
        end else if (blank_lz && m_disp1 == 4'd0) begin
          exp_seg = 7'h7F; exp_an = 2'b11;
        end else begin
          exp_seg = hex_tab[m_disp1]; exp_an = 2'b01;
        end
        exp_ack = (c == DIV - 1) && (load || m_pend);
        if (c == DIV - 1) begin
          if (load) begin
            m_sh0 = dig0; m_sh1 = dig1; m_disp0 = dig0; m_disp1 = dig1;
          end else if (m_pend) begin
            m_disp0 = m_sh0; m_disp1 = m_sh1;
          end
          m_pend = 1'b0;
        end else if (load) begin
          m_sh0 = dig0; m_sh1 = dig1; m_pend = 1'b1;
        end
        m_edges++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("model_seg", seg, exp_seg);
      check("model_an", an, exp_an);
      check("model_ack", ld_ack, exp_ack);
    end
  end

  // Driver: e = edges since release; the next edge sits at scan position e%PER.
  int e;
  int ack_seen;

  task automatic step();
    @(negedge clk);
    e++;
    if (ld_ack === 1'b1) ack_seen++;
  endtask

  task automatic goto_pos(input int p);
    while ((e % PER) != p) step();
  endtask

  task automatic load_at(input int p, input logic [3:0] d0, input logic [3:0] d1);
    goto_pos(p);
    load = 1'b1; dig0 = d0; dig1 = d1;
    step();
    load = 1'b0;
  endtask

  task automatic check_disp(input string name, input logic [1:0] want_an, input logic [6:0] want_seg);
    $display("check %s: an=%b seg=%h", name, an, seg);
    check({name, "_an"}, an, want_an);
    check({name, "_seg"}, seg, want_seg);
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; dig0 = 4'd0; dig1 = 4'd0; blank_lz = 1'b0;
    e = 0; ack_seen = 0;
    repeat (3) step();
    check_disp("reset", 2'b11, 7'h7F);
    check("reset_ack", ld_ack, 1'b0);

    // Idle scan after release
    rst_n = 1'b1; e = 0; ack_seen = 0;
    step(); check_disp("idle_e1", 2'b11, 7'h7F);
    step(); check_disp("idle_e2", 2'b11, 7'h7F);
    step(); check_disp("idle_e3", 2'b10, 7'h40);
    repeat (5) step(); check_disp("idle_e8", 2'b10, 7'h40);
    step(); check_disp("idle_e9", 2'b11, 7'h7F);
    step(); check_disp("idle_e10", 2'b11, 7'h7F);
    step(); check_disp("idle_e11", 2'b01, 7'h40);
    check("idle_no_ack", ack_seen, 0);

    // Mid-slot load waits for the boundary
    load_at(3, 4'd5, 4'd1);
    check_disp("mid_unchanged", 2'b10, 7'h40);
    ack_seen = 0;
    goto_pos(7);
    check("mid_ack_before", ld_ack, 1'b0);
    step(); check("mid_ack", ld_ack, 1'b1);
    step(); check("mid_ack_drop", ld_ack, 1'b0);
    goto_pos(12); step(); check_disp("mid_tens", 2'b01, 7'h79);
    goto_pos(4);  step(); check_disp("mid_ones", 2'b10, 7'h12);
    check("mid_ack_count", ack_seen, 1);

    // Two loads in one slot: last wins, one ack
    ack_seen = 0;
    load_at(1, 4'd3, 4'd4);
    load_at(4, 4'd9, 4'd2);
    goto_pos(12); step(); check_disp("dbl_tens", 2'b01, 7'h24);
    goto_pos(4);  step(); check_disp("dbl_ones", 2'b10, 7'h10);
    check("dbl_ack_count", ack_seen, 1);

    // Load coincident with the boundary
    ack_seen = 0;
    load_at(7, 4'hF, 4'hE);
    check("bnd_ack", ld_ack, 1'b1);
    goto_pos(12); step(); check_disp("bnd_tens", 2'b01, 7'h06);
    goto_pos(4);  step(); check_disp("bnd_ones", 2'b10, 7'h0E);
    check("bnd_ack_count", ack_seen, 1);

    // Leading-zero blanking, live input
    blank_lz = 1'b1;
    load_at(7, 4'd7, 4'd0);
    goto_pos(12); step(); check_disp("lz_tens", 2'b11, 7'h7F);
    goto_pos(4);  step(); check_disp("lz_ones", 2'b10, 7'h78);
    blank_lz = 1'b0;
    goto_pos(12); step(); check_disp("nolz_tens", 2'b01, 7'h40);

    // Reset mid-SHOW with a pending load
    load_at(3, 4'd8, 4'd8);
    step();
    #2 rst_n = 1'b0;
    #1 check_disp("arst_now", 2'b11, 7'h7F);
    check("arst_ack", ld_ack, 1'b0);
    repeat (2) step();
    rst_n = 1'b1; e = 0; ack_seen = 0;
    goto_pos(4);  step(); check_disp("arst_ones", 2'b10, 7'h40);
    goto_pos(12); step(); check_disp("arst_tens", 2'b01, 7'h40);
    repeat (8) step();
    check("arst_no_ack", ack_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sev_seg_scan.md
SEV_SEG_SCAN -- requirements
Module: sev_seg_scan

Interface
REQ-001 SHALL have parameter DIV, default 16'd50000: clock cycles per digit slot; legal range 4..65535.
REQ-002 SHALL have parameter BLANK_CYC, default 16'd500: anti-ghost blank cycles at the start of each slot; legal range 1..DIV-1.
REQ-003 SHALL have port clk  input  1: single rising-edge clock.
REQ-004 SHALL have port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port load  input  1: capture request for dig0/dig1, sampled each rising edge.
REQ-006 SHALL have port dig0  input  4: ones digit (driven by the adder/BCD stage seg1 output).
REQ-007 SHALL have port dig1  input  4: tens digit (driven by the adder/BCD stage seg2 output).
REQ-008 SHALL have port blank_lz  input  1: 1 = suppress dig1 when its displayed value is 0.
REQ-009 SHALL have port seg  output  7: active-low segments; seg[0]=a ... seg[6]=g; registered.
REQ-010 SHALL have port an  output  2: active-low digit enables; an[0]=ones, an[1]=tens; registered.
REQ-011 SHALL have port ld_ack  output  1: one-cycle pulse when captured digits reach the display registers.

Function
REQ-012 SHALL hold a 16-bit counter cnt, range 0..DIV-1; increments each cycle; at DIV-1 it wraps to 0 and toggles slot (0 = ones, 1 = tens).
REQ-013 SHALL compute each cycle from pre-edge cnt/slot/display registers, registered into seg/an at that edge (1-cycle latency):
  - cnt < BLANK_CYC: an=2'b11, seg=7'h7F (BLANK phase);
  - otherwise, slot 0: an=2'b10, seg=decode(disp0) (SHOW phase);
  - otherwise, slot 1: an=2'b01, seg=decode(disp1); if blank_lz=1 and disp1=0, an=2'b11 and seg=7'h7F.
REQ-014 SHALL decode active-low hex: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-015 SHALL, when load=1 at an edge with no slot boundary (cnt != DIV-1), write dig0/dig1 into shadow registers and set pending=1.
REQ-016 SHALL, at a slot boundary (cnt = DIV-1) with pending=1 and load=0, copy shadow to disp0/disp1, clear pending, and assert ld_ack for the next cycle.
REQ-017 SHALL, when load=1 at a slot boundary, write dig0/dig1 directly into shadow and disp0/disp1, clear pending, and assert ld_ack for the next cycle.
REQ-018 SHALL, on repeated load before transfer, overwrite shadow (last value wins) and issue exactly one ld_ack at the next boundary.
REQ-019 SHALL NOT change disp0/disp1 except at a slot boundary, so a digit never changes mid-slot.
REQ-020 SHALL keep ld_ack=0 at a boundary with pending=0 and load=0.
REQ-021 SHALL treat blank_lz as live (unlatched), sampled every cycle.

Reset
REQ-022 SHALL, while rst_n=0 (asynchronous), force cnt=0, slot=0, pending=0, shadow=0, disp0=disp1=0, seg=7'h7F, an=2'b11, ld_ack=0.
REQ-023 SHALL, on rst_n assertion mid-slot or with pending=1, discard pending data and emit no ld_ack after release.
REQ-024 SHALL resume at the first rising edge after rst_n deasserts, starting in the slot-0 BLANK phase.

Verification (DIV=8, BLANK_CYC=2)
REQ-025 Reset release, no load -> an=11 for 2 cycles, then an=10 and seg=7'h40 for 6 cycles, then an=01 and seg=7'h40 for 6 cycles; pattern repeats with 16-cycle period.
REQ-026 load pulse dig0=5, dig1=1 at cnt=3 -> display unchanged until boundary; ld_ack high exactly 1 cycle after cnt=7; next ones slot shows seg=7'h12, tens slot shows seg=7'h79.
REQ-027 Two loads (3/4, then 9/2) within one slot -> single ld_ack; display shows 9 (7'h10) and 2 (7'h24).
REQ-028 load coincident with cnt=7, dig0=F, dig1=E -> ld_ack next cycle; seg=7'h0E in the ones slot, seg=7'h06 in the tens slot.
REQ-029 blank_lz=1, disp1=0, disp0=7 -> tens slot an=11, seg=7'h7F; ones slot seg=7'h78; blank_lz=0 -> tens shows 7'h40.
REQ-030 rst_n pulled low mid-SHOW with pending=1 -> seg=7'h7F and an=11 immediately; after release, digits display 0 and no ld_ack occurs.
